// File: rtl/blob_feature_accum.sv
// Per-frame blob statistics: accumulates area and bounding box per label from a labeled
// pixel stream, then scans the table at frame end and emits qualifying blobs as records.
module blob_feature_accum #(
  parameter int unsigned IMG_HDISP   = 1280,
  parameter int unsigned IMG_VDISP   = 720,
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned MIN_AREA    = 16,
  parameter int unsigned MAX_AREA    = 65535
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   per_frame_vsync,
  input  logic                   per_frame_href,
  input  logic [LABEL_WIDTH-1:0] per_label,
  output logic                   blob_valid,
  input  logic                   blob_ready,
  output logic [LABEL_WIDTH-1:0] blob_label,
  output logic [19:0]            blob_area,
  output logic [10:0]            blob_xmin,
  output logic [10:0]            blob_xmax,
  output logic [9:0]             blob_ymin,
  output logic [9:0]             blob_ymax,
  output logic [LABEL_WIDTH:0]   blob_count,
  output logic                   frame_done,
  output logic                   frame_dropped,
  output logic                   busy
);

  localparam int unsigned Depth = 1 << LABEL_WIDTH;
  localparam logic [LABEL_WIDTH:0] ScanEnd = {1'b1, {LABEL_WIDTH{1'b0}}};
  localparam logic [10:0] XMax = 11'(IMG_HDISP - 1);
  localparam logic [9:0]  YMax = 10'(IMG_VDISP - 1);

  typedef struct packed {
    logic [19:0] area;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
  } entry_t;

  typedef enum logic [2:0] {StClear, StIdle, StAccum, StDrain, StScan, StDone} state_e;

  state_e                 state_q;
  logic                   vsync_q, href_q;
  logic [10:0]            x_q;
  logic [9:0]             y_q;
  logic [LABEL_WIDTH-1:0] clr_addr_q;
  logic                   drain_cnt_q;
  logic                   p_valid_q;
  logic [LABEL_WIDTH-1:0] p_label_q;
  logic [10:0]            p_x_q;
  logic [9:0]             p_y_q;
  logic                   wr_valid_q;
  logic [LABEL_WIDTH-1:0] wr_label_q;
  entry_t                 wr_data_q;
  logic [LABEL_WIDTH:0]   scan_addr_q;
  logic                   sc_valid_q;
  logic [LABEL_WIDTH-1:0] sc_addr_q;
  logic [LABEL_WIDTH:0]   rec_cnt_q;

  entry_t                 mem [Depth];
  entry_t                 rd_data;
  logic                   mem_re, mem_we;
  logic [LABEL_WIDTH-1:0] mem_raddr, mem_waddr;
  entry_t                 mem_wdata;

  logic   vs_rise, vs_fall, href_fall, pix_issue;
  logic   fwd, sc_qual, out_free, sc_consume, scan_issue, scan_end;
  entry_t base, upd;

  assign vs_rise   = per_frame_vsync & ~vsync_q;
  assign vs_fall   = ~per_frame_vsync & vsync_q;
  assign href_fall = href_q & ~per_frame_href;
  assign pix_issue = (state_q == StAccum) && per_frame_vsync && per_frame_href &&
                     (per_label != '0);
  assign busy      = (state_q != StIdle);

  // Back-to-back hits on one label: RAM data is stale, so reuse last cycle's write.
  assign fwd  = wr_valid_q && (wr_label_q == p_label_q);
  assign base = fwd ? wr_data_q : rd_data;

  always_comb begin
    upd = base;
    if (base.area == '0) begin
      upd.area = 20'd1;
      upd.xmin = p_x_q;
      upd.xmax = p_x_q;
      upd.ymin = p_y_q;
      upd.ymax = p_y_q;
    end else begin
      if (base.area != '1) upd.area = base.area + 20'd1;
      if (p_x_q < base.xmin) upd.xmin = p_x_q;
      if (p_x_q > base.xmax) upd.xmax = p_x_q;
      if (p_y_q < base.ymin) upd.ymin = p_y_q;
      if (p_y_q > base.ymax) upd.ymax = p_y_q;
    end
  end

  assign sc_qual    = (rd_data.area != '0) && (32'(rd_data.area) >= MIN_AREA) &&
                      (32'(rd_data.area) <= MAX_AREA);
  assign out_free   = ~blob_valid | blob_ready;
  assign sc_consume = sc_valid_q && out_free;
  assign scan_issue = (state_q == StScan) && (scan_addr_q != ScanEnd) && out_free;
  assign scan_end   = (state_q == StScan) && (scan_addr_q == ScanEnd) && !sc_valid_q &&
                      out_free;

  always_comb begin
    mem_re    = pix_issue | scan_issue;
    mem_raddr = scan_issue ? scan_addr_q[LABEL_WIDTH-1:0] : per_label;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
    end else if (p_valid_q) begin
      mem_we    = 1'b1;
      mem_waddr = p_label_q;
      mem_wdata = upd;
    end else if (sc_consume) begin
      mem_we    = 1'b1;
      mem_waddr = sc_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_re) rd_data <= mem[mem_raddr];
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StClear;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      clr_addr_q    <= '0;
      drain_cnt_q   <= 1'b0;
      p_valid_q     <= 1'b0;
      p_label_q     <= '0;
      p_x_q         <= '0;
      p_y_q         <= '0;
      wr_valid_q    <= 1'b0;
      wr_label_q    <= '0;
      wr_data_q     <= '0;
      scan_addr_q   <= '0;
      sc_valid_q    <= 1'b0;
      sc_addr_q     <= '0;
      rec_cnt_q     <= '0;
      blob_valid    <= 1'b0;
      blob_label    <= '0;
      blob_area     <= '0;
      blob_xmin     <= '0;
      blob_xmax     <= '0;
      blob_ymin     <= '0;
      blob_ymax     <= '0;
      blob_count    <= '0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;

      if (vs_rise) begin
        x_q <= '0;
        y_q <= '0;
      end else if (href_fall) begin
        x_q <= '0;
        if (y_q != YMax) y_q <= y_q + 10'd1;
      end else if (per_frame_href && (x_q != XMax)) begin
        x_q <= x_q + 11'd1;
      end

      p_valid_q  <= pix_issue;
      p_label_q  <= per_label;
      p_x_q      <= x_q;
      p_y_q      <= y_q;
      wr_valid_q <= p_valid_q;
      wr_label_q <= p_label_q;
      wr_data_q  <= upd;

      if (scan_issue) begin
        scan_addr_q <= scan_addr_q + (LABEL_WIDTH+1)'(1);
        sc_valid_q  <= 1'b1;
        sc_addr_q   <= scan_addr_q[LABEL_WIDTH-1:0];
      end else if (sc_consume) begin
        sc_valid_q  <= 1'b0;
      end

      if (sc_consume && sc_qual) begin
        blob_valid <= 1'b1;
        blob_label <= sc_addr_q;
        blob_area  <= rd_data.area;
        blob_xmin  <= rd_data.xmin;
        blob_xmax  <= rd_data.xmax;
        blob_ymin  <= rd_data.ymin;
        blob_ymax  <= rd_data.ymax;
      end else if (blob_ready) begin
        blob_valid <= 1'b0;
      end

      if (blob_valid && blob_ready) rec_cnt_q <= rec_cnt_q + (LABEL_WIDTH+1)'(1);

      frame_done    <= 1'b0;
      frame_dropped <= vs_rise && (state_q != StIdle) && (state_q != StAccum);

      unique case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + LABEL_WIDTH'(1);
          if (&clr_addr_q) state_q <= StIdle;
        end
        StIdle: if (vs_rise) state_q <= StAccum;
        StAccum: begin
          if (vs_fall) begin
            state_q     <= StDrain;
            drain_cnt_q <= 1'b0;
          end
        end
        StDrain: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) begin
            state_q     <= StScan;
            scan_addr_q <= (LABEL_WIDTH+1)'(1);
            rec_cnt_q   <= '0;
          end
        end
        StScan: if (scan_end) state_q <= StDone;
        StDone: begin
          blob_count <= rec_cnt_q;
          frame_done <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StClear;
      endcase
    end
  end

endmodule

// File: tb/tb_blob_feature_accum.sv
// Directed bench for blob_feature_accum: small image, 16-entry table, area window [4, 40].
module tb_blob_feature_accum;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          rst_n, vsync, href, blob_ready;
  logic [LW-1:0] lbl_in;
  logic          blob_valid, frame_done, frame_dropped, busy;
  logic [LW-1:0] blob_label;
  logic [19:0]   blob_area;
  logic [10:0]   blob_xmin, blob_xmax;
  logic [9:0]    blob_ymin, blob_ymax;
  logic [LW:0]   blob_count;

  always #5 clk = ~clk;

  blob_feature_accum #(
    .IMG_HDISP(64), .IMG_VDISP(32), .LABEL_WIDTH(LW), .MIN_AREA(4), .MAX_AREA(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
    .per_label(lbl_in), .blob_valid(blob_valid), .blob_ready(blob_ready),
    .blob_label(blob_label), .blob_area(blob_area), .blob_xmin(blob_xmin),
    .blob_xmax(blob_xmax), .blob_ymin(blob_ymin), .blob_ymax(blob_ymax),
    .blob_count(blob_count), .frame_done(frame_done), .frame_dropped(frame_dropped),
    .busy(busy)
  );

  int n_checks = 0, n_fail = 0, n_drop = 0;
  logic [LW-1:0] img [0:15][0:79];
  int nrec, got_done, got_count, unstable;
  int rec_label[8], rec_area[8], rec_xmin[8], rec_xmax[8], rec_ymin[8], rec_ymax[8];
  int rec_cyc[8];

  task automatic tick();
    @(negedge clk);
    if (frame_dropped) n_drop++;
  endtask

  task automatic clear_img();
    for (int y = 0; y < 16; y++) for (int x = 0; x < 80; x++) img[y][x] = '0;
  endtask

  task automatic put_rect(input int lbl, input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) img[y][x] = LW'(lbl);
  endtask

  task automatic drive_frame(input int lines, input int pix);
    vsync = 1'b1;
    tick(); tick(); tick();
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < pix; x++) begin
        href = 1'b1;
        lbl_in = img[y][x];
        tick();
      end
      href = 1'b0;
      lbl_in = '0;
      tick(); tick(); tick();
    end
    vsync = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input string name);
    int c = 0;
    while (!blob_valid && c < 300) begin tick(); c++; end
    n_checks++;
    if (blob_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_wait_valid: got %0b expected 1", name, blob_valid);
    end
  endtask

  // Gathers records until frame_done; bp=1 holds ready low for 10 valid cycles, then toggles.
  task automatic collect(input bit bp);
    logic [65:0] cur, saved;
    bit v, rdy, prev_stall;
    int vcnt, cyc;
    nrec = 0; got_done = 0; got_count = -1; unstable = 0;
    prev_stall = 0; vcnt = 0; cyc = 0; saved = '0;
    for (int i = 0; i < 8; i++) begin
      rec_label[i] = -1; rec_area[i] = -1; rec_xmin[i] = -1; rec_xmax[i] = -1;
      rec_ymin[i] = -1; rec_ymax[i] = -1; rec_cyc[i] = -1;
    end
    while (!got_done && cyc < 600) begin
      v = blob_valid;
      cur = {blob_label, blob_area, blob_xmin, blob_xmax, blob_ymin, blob_ymax};
      if (prev_stall && (!v || cur !== saved)) unstable++;
      if (frame_done) begin got_done = 1; got_count = int'(blob_count); end
      rdy = bp ? ((vcnt >= 10) && (vcnt % 2 == 0)) : 1'b1;
      if (v) vcnt++;
      blob_ready = rdy;
      if (v && rdy) begin
        if (nrec < 8) begin
          rec_label[nrec] = int'(blob_label); rec_area[nrec] = int'(blob_area);
          rec_xmin[nrec] = int'(blob_xmin); rec_xmax[nrec] = int'(blob_xmax);
          rec_ymin[nrec] = int'(blob_ymin); rec_ymax[nrec] = int'(blob_ymax);
          rec_cyc[nrec] = cyc;
        end
        nrec++;
      end
      prev_stall = v && !rdy;
      saved = cur;
      if (!got_done) begin tick(); cyc++; end
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; lbl_in = '0; blob_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (blob_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", blob_valid); end
    n_checks++;
    if ({blob_label, blob_area, blob_xmin, blob_xmax, blob_ymin, blob_ymax, blob_count} !== '0) begin
      n_fail++; $display("FAIL rst_fields: got %0h expected 0", {blob_label, blob_area, blob_xmin, blob_xmax, blob_ymin, blob_ymax, blob_count});
    end
    n_checks++; if ({frame_done, frame_dropped} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got %0b expected 00", {frame_done, frame_dropped}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b expected 1", busy); end
    rst_n = 1'b1;
    while (busy && cnt < 100) begin cnt++; tick(); end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL rst_clear_cycles: got %0d expected 16", cnt); end
  endtask

  task automatic test_single_blob();
    clear_img(); put_rect(5, 10, 12, 4, 6);
    n_drop = 0;
    drive_frame(8, 16); collect(0);
    n_checks++; if (got_done != 1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", got_done); end
    n_checks++; if (nrec != 1) begin n_fail++; $display("FAIL single_nrec: got %0d expected 1", nrec); end
    n_checks++; if (rec_label[0] != 5) begin n_fail++; $display("FAIL single_label: got %0d expected 5", rec_label[0]); end
    n_checks++; if (rec_area[0] != 9) begin n_fail++; $display("FAIL single_area: got %0d expected 9", rec_area[0]); end
    n_checks++; if (rec_xmin[0] != 10 || rec_xmax[0] != 12) begin n_fail++; $display("FAIL single_x: got %0d..%0d expected 10..12", rec_xmin[0], rec_xmax[0]); end
    n_checks++; if (rec_ymin[0] != 4 || rec_ymax[0] != 6) begin n_fail++; $display("FAIL single_y: got %0d..%0d expected 4..6", rec_ymin[0], rec_ymax[0]); end
    n_checks++; if (got_count != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_count); end
    n_checks++; if (n_drop != 0) begin n_fail++; $display("FAIL single_no_drop: got %0d expected 0", n_drop); end
  endtask

  task automatic test_forwarding();
    clear_img(); put_rect(7, 0, 19, 0, 0); put_rect(7, 0, 0, 1, 1);
    drive_frame(2, 24); collect(0);
    n_checks++; if (nrec != 1 || rec_label[0] != 7) begin n_fail++; $display("FAIL fwd_rec: got n=%0d lbl=%0d expected n=1 lbl=7", nrec, rec_label[0]); end
    n_checks++; if (rec_area[0] != 21) begin n_fail++; $display("FAIL fwd_area: got %0d expected 21", rec_area[0]); end
    n_checks++; if (rec_xmin[0] != 0 || rec_xmax[0] != 19) begin n_fail++; $display("FAIL fwd_x: got %0d..%0d expected 0..19", rec_xmin[0], rec_xmax[0]); end
    n_checks++; if (rec_ymin[0] != 0 || rec_ymax[0] != 1) begin n_fail++; $display("FAIL fwd_y: got %0d..%0d expected 0..1", rec_ymin[0], rec_ymax[0]); end
  endtask

  task automatic test_x_saturation();
    clear_img(); put_rect(9, 60, 69, 0, 0);
    drive_frame(1, 70); collect(0);
    n_checks++; if (nrec != 1 || rec_area[0] != 10) begin n_fail++; $display("FAIL xsat_area: got n=%0d area=%0d expected n=1 area=10", nrec, rec_area[0]); end
    n_checks++; if (rec_xmin[0] != 60 || rec_xmax[0] != 63) begin n_fail++; $display("FAIL xsat_x: got %0d..%0d expected 60..63", rec_xmin[0], rec_xmax[0]); end
  endtask

  task automatic test_area_filter();
    clear_img();
    put_rect(2, 0, 2, 0, 0); put_rect(3, 4, 7, 0, 0);
    put_rect(4, 0, 40, 1, 1); put_rect(10, 0, 39, 2, 2);
    drive_frame(3, 48); collect(0);
    n_checks++; if (nrec != 2) begin n_fail++; $display("FAIL filt_nrec: got %0d expected 2", nrec); end
    n_checks++; if (rec_label[0] != 3 || rec_area[0] != 4) begin n_fail++; $display("FAIL filt_min: got lbl=%0d area=%0d expected lbl=3 area=4", rec_label[0], rec_area[0]); end
    n_checks++; if (rec_xmin[0] != 4 || rec_xmax[0] != 7) begin n_fail++; $display("FAIL filt_min_x: got %0d..%0d expected 4..7", rec_xmin[0], rec_xmax[0]); end
    n_checks++; if (rec_label[1] != 10 || rec_area[1] != 40) begin n_fail++; $display("FAIL filt_max: got lbl=%0d area=%0d expected lbl=10 area=40", rec_label[1], rec_area[1]); end
    n_checks++; if (rec_ymin[1] != 2 || rec_xmax[1] != 39) begin n_fail++; $display("FAIL filt_max_box: got ymin=%0d xmax=%0d expected ymin=2 xmax=39", rec_ymin[1], rec_xmax[1]); end
    n_checks++; if (got_count != 2) begin n_fail++; $display("FAIL filt_count: got %0d expected 2", got_count); end
  endtask

  task automatic test_back_to_back();
    clear_img(); put_rect(5, 0, 1, 0, 1); put_rect(6, 3, 4, 0, 1);
    drive_frame(2, 8); collect(0);
    n_checks++; if (nrec != 2 || rec_label[0] != 5 || rec_label[1] != 6) begin n_fail++; $display("FAIL b2b_labels: got n=%0d %0d,%0d expected n=2 5,6", nrec, rec_label[0], rec_label[1]); end
    n_checks++; if (rec_cyc[1] - rec_cyc[0] != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 1", rec_cyc[1] - rec_cyc[0]); end
  endtask

  task automatic test_backpressure();
    clear_img(); put_rect(1, 0, 1, 0, 1); put_rect(12, 3, 7, 2, 2);
    drive_frame(3, 10); collect(1);
    n_checks++; if (nrec != 2) begin n_fail++; $display("FAIL bp_nrec: got %0d expected 2", nrec); end
    n_checks++; if (rec_label[0] != 1 || rec_label[1] != 12) begin n_fail++; $display("FAIL bp_order: got %0d,%0d expected 1,12", rec_label[0], rec_label[1]); end
    n_checks++; if (rec_area[0] != 4 || rec_area[1] != 5) begin n_fail++; $display("FAIL bp_area: got %0d,%0d expected 4,5", rec_area[0], rec_area[1]); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
    n_checks++; if (got_count != 2) begin n_fail++; $display("FAIL bp_count: got %0d expected 2", got_count); end
  endtask

  task automatic test_dropped_frame();
    clear_img(); put_rect(3, 0, 1, 0, 1); put_rect(11, 4, 5, 0, 1);
    blob_ready = 1'b0;
    drive_frame(2, 8);
    wait_valid("drop");
    clear_img(); put_rect(8, 0, 7, 0, 1);
    n_drop = 0;
    drive_frame(2, 8);
    n_checks++; if (n_drop != 1) begin n_fail++; $display("FAIL drop_pulse: got %0d expected 1", n_drop); end
    collect(0);
    n_checks++; if (nrec != 2 || rec_label[0] != 3 || rec_label[1] != 11) begin n_fail++; $display("FAIL drop_first: got n=%0d %0d,%0d expected n=2 3,11", nrec, rec_label[0], rec_label[1]); end
    clear_img(); put_rect(8, 2, 3, 0, 1);
    drive_frame(2, 8); collect(0);
    n_checks++; if (nrec != 1 || rec_label[0] != 8 || rec_area[0] != 4) begin n_fail++; $display("FAIL drop_next: got n=%0d lbl=%0d area=%0d expected n=1 lbl=8 area=4", nrec, rec_label[0], rec_area[0]); end
    n_checks++; if (rec_xmin[0] != 2) begin n_fail++; $display("FAIL drop_next_x: got %0d expected 2", rec_xmin[0]); end
  endtask

  task automatic test_reset_mid_scan();
    int cnt = 0;
    clear_img(); put_rect(2, 0, 1, 0, 1); put_rect(6, 4, 5, 0, 1);
    blob_ready = 1'b0;
    drive_frame(2, 8);
    wait_valid("midrst");
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_checks++; if (blob_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 0", blob_valid); end
    while (busy && cnt < 100) begin cnt++; tick(); end
    n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL midrst_clear_cycles: got %0d expected 16", cnt); end
    clear_img(); put_rect(9, 0, 1, 0, 1);
    drive_frame(2, 8); collect(0);
    n_checks++; if (nrec != 1 || rec_label[0] != 9) begin n_fail++; $display("FAIL midrst_stale: got n=%0d lbl=%0d expected n=1 lbl=9", nrec, rec_label[0]); end
    n_checks++; if (got_count != 1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", got_count); end
  endtask

  initial begin
    test_reset();
    test_single_blob();
    test_forwarding();
    test_x_saturation();
    test_area_filter();
    test_back_to_back();
    test_backpressure();
    test_dropped_frame();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
